// File: rtl/cdc_req_arbiter.sv
// Round-robin arbiter granting one clk-domain resource to N_REQ asynchronous
// 4-phase req/ack requesters; each request is resynchronized before arbitration.
module cdc_req_arbiter #(
   parameter int N_REQ  = 4,
   parameter int STAGES = 2,
   localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_done,
   output logic [N_REQ-1:0] o_ack,
   output logic             o_gnt_vld,
   output logic [IDW-1:0]   o_gnt_id,
   output logic             o_busy,
   output logic             o_err
);

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   state_t                         state;
   logic [IDW-1:0]                 rr_ptr;
   logic                           err_flagged;
   logic [N_REQ-1:0][STAGES-1:0]   sync_q;
   logic [N_REQ-1:0]               req_s;
   logic [IDW-1:0]                 winner;
   logic [IDW-1:0]                 next_ptr;

   // Reverse scan so the last hit is the first requester at or after ptr.
   function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [IDW-1:0]   ptr);
      int idx;
      rr_pick = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (req[idx]) rr_pick = IDW'(idx);
      end
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_q <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++)
            sync_q[i] <= {sync_q[i][STAGES-2:0], i_req[i]};
      end
   end

   // NOTE: every always_comb output gets a default first, so no latch can be inferred.
   always_comb begin
      req_s    = '0;
      for (int i = 0; i < N_REQ; i++) req_s[i] = sync_q[i][STAGES-1];
      winner   = rr_pick(req_s, rr_ptr);
      next_ptr = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         err_flagged <= 1'b0;
         o_ack       <= '0;
         o_gnt_vld   <= 1'b0;
         o_gnt_id    <= '0;
         o_busy      <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         o_err <= 1'b0;
         case (state)
            IDLE: begin
               if (|req_s) begin
                  state       <= BUSY;
                  o_gnt_vld   <= 1'b1;
                  o_gnt_id    <= winner;
                  rr_ptr      <= next_ptr;
                  o_busy      <= 1'b1;
                  err_flagged <= 1'b0;
               end
            end
            BUSY: begin
               // A withdrawn request is reported once; the grant still waits for done.
               if (!req_s[o_gnt_id] && !err_flagged) begin
                  o_err       <= 1'b1;
                  err_flagged <= 1'b1;
               end
               if (i_done) begin
                  o_gnt_vld <= 1'b0;
                  if (req_s[o_gnt_id]) begin
                     state           <= ACK;
                     o_ack[o_gnt_id] <= 1'b1;
                  end else begin
                     state  <= IDLE;
                     o_busy <= 1'b0;
                  end
               end
            end
            ACK: begin
               if (!req_s[o_gnt_id]) begin
                  o_ack  <= '0;
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               o_ack  <= '0;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_req_arbiter.sv
// Self-checking bench for cdc_req_arbiter (N_REQ=4, STAGES=2): a per-cycle
// vector table plus hand-written multi-handshake sequences.
module tb_cdc_req_arbiter;

   localparam int N_REQ  = 4;
   localparam int STAGES = 2;
   localparam int IDW    = 2;

   logic             clk = 1'b0;
   logic             rstn;
   logic [N_REQ-1:0] i_req;
   logic             i_done;
   logic [N_REQ-1:0] o_ack;
   logic             o_gnt_vld;
   logic [IDW-1:0]   o_gnt_id;
   logic             o_busy;
   logic             o_err;

   int n_cmp = 0;
   int n_err = 0;

   cdc_req_arbiter #(.N_REQ(N_REQ), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .i_req     (i_req),
      .i_done    (i_done),
      .o_ack     (o_ack),
      .o_gnt_vld (o_gnt_vld),
      .o_gnt_id  (o_gnt_id),
      .o_busy    (o_busy),
      .o_err     (o_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             rstn;
      logic [N_REQ-1:0] req;
      logic             done;
      logic [N_REQ-1:0] ack;
      logic             vld;
      logic [IDW-1:0]   id;
      logic             busy;
      logic             err;
   } vec_t;

   vec_t vecs [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int exp_id);
      for (int c = 0; c < 20 && !o_gnt_vld; c++) step();
      check("grant_seen", 32'(o_gnt_vld), 32'd1);
      check("grant_id", 32'(o_gnt_id), 32'(exp_id));
   endtask

   task automatic complete(input int exp_id, input logic [N_REQ-1:0] req_after, input logic reraise);
      i_done = 1'b1;
      step();
      i_done = 1'b0;
      check("ack_onehot", 32'(o_ack), 32'(1 << exp_id));
      check("ack_gnt_low", 32'(o_gnt_vld), 32'd0);
      i_req = req_after;
      for (int c = 0; c < 10 && o_ack != '0; c++) step();
      check("ack_released", 32'(o_ack), 32'd0);
      check("idle_after_ack", 32'(o_busy), 32'd0);
      if (reraise) i_req[exp_id] = 1'b1;
   endtask

   task automatic handshake(input int exp_id, input logic [N_REQ-1:0] req_after, input logic reraise);
      wait_grant(exp_id);
      complete(exp_id, req_after, reraise);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100us");
      $fatal(1);
   end

   initial begin
      rstn   = 1'b0;
      i_req  = '0;
      i_done = 1'b0;

      //          rstn  req      done  ack      vld   id     busy  err
      vecs[0]  = {1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
      vecs[1]  = {1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
      vecs[2]  = {1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
      vecs[3]  = {1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
      vecs[4]  = {1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
      vecs[5]  = {1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0};
      vecs[6]  = {1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0};
      vecs[7]  = {1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0};
      vecs[8]  = {1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0};
      vecs[9]  = {1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
      vecs[10] = {1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
      vecs[11] = {1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
      vecs[12] = {1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
      vecs[13] = {1'b1, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
      vecs[14] = {1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
      vecs[15] = {1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
      vecs[16] = {1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b1};
      vecs[17] = {1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
      vecs[18] = {1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0};
      vecs[19] = {1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0};

      // Reset, single handshake on requester 2, done in first BUSY cycle,
      // done ignored in ACK/IDLE, then withdrawal of requester 1.
      for (int v = 0; v < 20; v++) begin
         rstn   = vecs[v].rstn;
         i_req  = vecs[v].req;
         i_done = vecs[v].done;
         step();
         check($sformatf("v%0d_ack", v),  32'(o_ack),     32'(vecs[v].ack));
         check($sformatf("v%0d_vld", v),  32'(o_gnt_vld), 32'(vecs[v].vld));
         check($sformatf("v%0d_busy", v), 32'(o_busy),    32'(vecs[v].busy));
         check($sformatf("v%0d_err", v),  32'(o_err),     32'(vecs[v].err));
         if (vecs[v].vld)
            check($sformatf("v%0d_id", v), 32'(o_gnt_id), 32'(vecs[v].id));
      end

      // Reset while in ACK: rr_ptr is 2 here, grant 2 and reach ACK.
      i_req = 4'b0100;
      wait_grant(2);
      i_done = 1'b1;
      step();
      i_done = 1'b0;
      check("pre_reset_ack", 32'(o_ack), 32'h4);
      rstn  = 1'b0;
      i_req = '0;
      step();
      check("rst_ack",  32'(o_ack),     32'd0);
      check("rst_vld",  32'(o_gnt_vld), 32'd0);
      check("rst_id",   32'(o_gnt_id),  32'd0);
      check("rst_busy", 32'(o_busy),    32'd0);
      check("rst_err",  32'(o_err),     32'd0);
      rstn = 1'b1;

      // Round-robin with all requesters held: order 0,1,2,3,0 (also proves rr_ptr reset).
      i_req = 4'b1111;
      handshake(0, 4'b1110, 1'b1);
      handshake(1, 4'b1101, 1'b1);
      handshake(2, 4'b1011, 1'b1);
      handshake(3, 4'b0111, 1'b1);
      handshake(0, 4'b0000, 1'b0);

      // rr_ptr=1: lone request 3 wins; 0 and 1 arrive together while 3 is busy.
      step();
      check("idle_before_t3", 32'(o_busy), 32'd0);
      i_req = 4'b1000;
      wait_grant(3);
      i_req = 4'b1011;
      complete(3, 4'b0011, 1'b0);
      handshake(0, 4'b0010, 1'b0);
      handshake(1, 4'b0000, 1'b0);
      step();
      step();
      check("final_busy", 32'(o_busy),    32'd0);
      check("final_vld",  32'(o_gnt_vld), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
